// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: FSM state
// encoding and the requester count/index width.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int unsigned ARB_N     = 8;
   localparam int unsigned ARB_IDX_W = 3;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate the request vector so the pointer
// position lands at bit 0, find the lowest set bit, then add the pointer
// back to recover the absolute requester index.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]     req_i,
   input  logic [ARB_IDX_W-1:0] ptr_i,
   output logic [ARB_IDX_W-1:0] win_idx_o,
   output logic                 win_any_o
);

   logic [ARB_N-1:0]     rot;
   logic [ARB_IDX_W-1:0] offs;
   logic                 found;

   // Rotate right by ptr, priority-find from bit 0, un-rotate by adding ptr
   always_comb begin
      rot   = ARB_N'({req_i, req_i} >> ptr_i);
      offs  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < ARB_N; i++) begin
         if (!found && rot[i]) begin
            offs  = ARB_IDX_W'(i);
            found = 1'b1;
         end
      end
      win_idx_o = ptr_i + offs;
      win_any_o = |req_i;
   end

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with held grants. All outputs are registered;
// grant is one-hot while owned and all-zero otherwise.
// Optional forced release after MAX_HOLD cycles: define RR_ARBITER8_TIMEOUT_EN.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ARB_N-1:0] req_i,
   input  logic             release_i,
   output logic [ARB_N-1:0] grant_o,
   output logic             grant_valid_o,
   output logic             timeout_o
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be in 1..255");
   end

   arb_state_e           state_q;
   logic [ARB_N-1:0]     grant_q;
   logic                 grant_valid_q;
   logic [ARB_IDX_W-1:0] ptr_q;
   logic [ARB_IDX_W-1:0] owner_q;

   logic [ARB_IDX_W-1:0] win_idx;
   logic                 win_any;
   logic [ARB_N-1:0]     win_onehot_d;
   logic                 expire;

   rr_pick8 u_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .win_idx_o (win_idx),
      .win_any_o (win_any)
   );

   // One-hot decode of the winning index
   always_comb begin
      win_onehot_d          = '0;
      win_onehot_d[win_idx] = 1'b1;
   end

`ifdef RR_ARBITER8_TIMEOUT_EN
   logic [7:0] hold_cnt_q;
   logic       timeout_q;

   assign expire = (hold_cnt_q == 8'(MAX_HOLD - 1));

   // Hold counter and timeout pulse; a coincident release wins over expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (state_q == IDLE) begin
            hold_cnt_q <= '0;
         end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
            if (expire && !release_i) begin
               timeout_q <= 1'b1;
            end
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Arbitration FSM: grant in IDLE, hold in GRANT until release or expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         ptr_q         <= '0;
         owner_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  state_q       <= GRANT;
                  grant_q       <= win_onehot_d;
                  grant_valid_q <= 1'b1;
                  owner_q       <= win_idx;
               end
            end
            GRANT: begin
               if (release_i || expire) begin
                  state_q       <= IDLE;
                  grant_q       <= '0;
                  grant_valid_q <= 1'b0;
                  ptr_q         <= owner_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = grant_valid_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8. Timeout cases are included when
// RR_ARBITER8_TIMEOUT_EN is defined (bench instantiates MAX_HOLD = 4).
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = '0;
   logic       rel = 1'b0;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   rr_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .release_i     (rel),
      .grant_o       (grant),
      .grant_valid_o (grant_valid),
      .timeout_o     (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full output check against expected grant; valid and timeout derived
   task automatic check_out(input string tag, input logic [7:0] g, input logic to);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".valid"}, 32'(grant_valid), 32'(g != 8'h00));
      check({tag, ".timeout"}, 32'(timeout), 32'(to));
   endtask

   task automatic do_release(input string tag);
      rel = 1'b1;
      step();
      rel = 1'b0;
      check_out(tag, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] exp_g;

      // Reset with all requests asserted
      rst = 1'b1;
      req = 8'hFF;
      step();
      step();
      check_out("reset", 8'h00, 1'b0);
      rst = 1'b0;
      step();
      check_out("first_grant", 8'h01, 1'b0);
      do_release("first_rel");

      // Rotation 02..80 then wrap to 01, zero cycle after each release
      for (int i = 1; i <= 8; i++) begin
         exp_g = 8'h01 << (i % 8);
         step();
         check_out($sformatf("rot%0d", i), exp_g, 1'b0);
         do_release($sformatf("rot%0d_gap", i));
      end
      req = 8'h00;

      // Single request held after request drops (ptr now 1)
      req = 8'h10;
      step();
      check_out("single", 8'h10, 1'b0);
      req = 8'h00;
      step();
      check_out("single_hold1", 8'h10, 1'b0);
      step();
      check_out("single_hold2", 8'h10, 1'b0);
      do_release("single_rel");

      // Skipping: grant 5, release -> ptr 6; req 09 wraps to 01
      req = 8'h20;
      step();
      check_out("grant5", 8'h20, 1'b0);
      req = 8'h00;
      do_release("grant5_rel");
      req = 8'h09;
      step();
      check_out("skip_wrap", 8'h01, 1'b0);
      do_release("skip_wrap_rel");
      req = 8'h08;
      step();
      check_out("skip_08", 8'h08, 1'b0);
      req = 8'h00;
      do_release("skip_08_rel");

      // Release in IDLE is ignored (ptr stays 4)
      rel = 1'b1;
      step();
      rel = 1'b0;
      check_out("idle_rel", 8'h00, 1'b0);
      step();
      check_out("idle_rel2", 8'h00, 1'b0);
      req = 8'h04;
      step();
      check_out("grant2", 8'h04, 1'b0);

      // Reset mid-grant returns pointer to 0
      rst = 1'b1;
      step();
      check_out("mid_reset", 8'h00, 1'b0);
      rst = 1'b0;
      req = 8'h06;
      step();
      check_out("post_reset", 8'h02, 1'b0);
      req = 8'h00;
      do_release("post_reset_rel");

`ifdef RR_ARBITER8_TIMEOUT_EN
      // Forced release after 4 cycles (ptr 2 -> search wraps to 0)
      req = 8'h01;
      for (int c = 1; c <= 4; c++) begin
         step();
         check_out($sformatf("to_hold%0d", c), 8'h01, 1'b0);
      end
      step();
      check_out("to_pulse", 8'h00, 1'b1);
      req = 8'h00;
      step();
      check_out("to_after", 8'h00, 1'b0);

      // Release on cycle 4 coincides with expiry: no timeout pulse
      req = 8'h01;
      for (int c = 1; c <= 4; c++) begin
         step();
         check_out($sformatf("rel4_hold%0d", c), 8'h01, 1'b0);
      end
      req = 8'h00;
      do_release("rel4_rel");
      step();
      check_out("rel4_after", 8'h00, 1'b0);
`else
      // Without the timeout feature a grant persists indefinitely
      req = 8'h01;
      step();
      check_out("long_start", 8'h01, 1'b0);
      req = 8'h00;
      for (int c = 0; c < 20; c++) begin
         step();
      end
      check_out("long_hold", 8'h01, 1'b0);
      do_release("long_rel");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_rr_arbiter8
